mbist_step_scheduler: RTL



---
 rtl/mbist_sched_pkg.sv | 30 +++
 rtl/mbist_sched_counter.sv | 29 ++
 rtl/mbist_step_scheduler.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mbist_sched_pkg.sv
// Shared state encoding, default parameters and helpers for the BIST step scheduler.
package mbist_sched_pkg;

  localparam int MAX_CTRL        = 16;
  localparam int IDX_W           = 4;
  localparam int DEF_NUM_CTRL    = 4;
  localparam int DEF_SETTLE_CYC  = 4;
  localparam int DEF_TIMEOUT_W   = 16;
  localparam int DEF_TIMEOUT_CYC = 50000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_SETTLE,
    ST_RUN,
    ST_RELEASE,
    ST_FINISH
  } schedState_t;

  // Scanning from the top lets the lowest set bit win.
  function automatic logic [IDX_W-1:0] lowestSetIdx(input logic [MAX_CTRL-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_CTRL - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mbist_sched_counter.sv
// Loadable saturating up-counter, shared by the settle window and the RUN watchdog.
module mbist_sched_counter
  import mbist_sched_pkg::*;
#(
  parameter int W = DEF_TIMEOUT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         i_load,
  input  logic [W-1:0] i_loadVal,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_loadVal;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mbist_step_scheduler.sv
// Steps through memory BIST controllers lowest index first, steering the clock-inversion mux per step.
// Optional RUN watchdog enabled by defining MBIST_SCHED_TIMEOUT_EN.
module mbist_step_scheduler
  import mbist_sched_pkg::*;
#(
  parameter int NUM_CTRL    = DEF_NUM_CTRL,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
  parameter int TIMEOUT_W   = DEF_TIMEOUT_W,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic [NUM_CTRL-1:0] enable_mask_i,
  input  logic [NUM_CTRL-1:0] invert_mask_i,
  output logic [NUM_CTRL-1:0] ctrl_start_o,
  input  logic [NUM_CTRL-1:0] ctrl_done_i,
  input  logic [NUM_CTRL-1:0] ctrl_fail_i,
  output logic                clk_inv_sel_o,
  output logic                busy_o,
  output logic                done_o,
  output logic                pass_o,
  output logic [NUM_CTRL-1:0] fail_vec_o,
  output logic                timeout_o
);

  localparam logic [TIMEOUT_W-1:0] SETTLE_LAST = TIMEOUT_W'(SETTLE_CYC - 1);
  localparam logic [TIMEOUT_W-1:0] WDOG_LAST   = TIMEOUT_W'(TIMEOUT_CYC - 1);

  schedState_t r_state;
  schedState_t w_nextState;

  logic [NUM_CTRL-1:0] r_pending;
  logic [NUM_CTRL-1:0] r_inv;
  logic [NUM_CTRL-1:0] r_sel;
  logic [NUM_CTRL-1:0] r_failVec;
  logic                r_clkInvSel;
  logic                r_timeout;
  logic                r_pass;

  logic [MAX_CTRL-1:0]  w_pendWide;
  logic [IDX_W-1:0]     w_lowIdx;
  logic [NUM_CTRL-1:0]  w_lowOh;
  logic [TIMEOUT_W-1:0] w_count;
  logic                 w_cntLoad;
  logic                 w_cntInc;
  logic                 w_abortNow;
  logic                 w_activeDone;
  logic                 w_activeFail;
  logic                 w_polFlip;
  logic                 w_runDone;
  logic                 w_runTimeout;
  logic                 w_enterFinish;

  // Pick the next controller as a one-hot so all per-index lookups become masks.
  always_comb begin
    w_pendWide = '0;
    w_pendWide[NUM_CTRL-1:0] = r_pending;
    w_lowIdx = lowestSetIdx(w_pendWide);
    w_lowOh = '0;
    for (int i = 0; i < NUM_CTRL; i++) begin
      w_lowOh[i] = (w_lowIdx == IDX_W'(i));
    end
  end

  assign w_activeDone = |(ctrl_done_i & r_sel);
  assign w_activeFail = |(ctrl_fail_i & r_sel);
  assign w_abortNow   = abort_i && (r_state != ST_IDLE) && (r_state != ST_FINISH);

  mbist_sched_counter #(
    .W(TIMEOUT_W)
  ) u_counter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .i_load   (w_cntLoad),
    .i_loadVal('0),
    .i_inc    (w_cntInc),
    .o_count  (w_count)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_nextState;
  end

  // Abort outranks every other exit; done outranks the watchdog.
  always_comb begin
    w_nextState  = r_state;
    w_polFlip    = 1'b0;
    w_runDone    = 1'b0;
    w_runTimeout = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start_i) w_nextState = ST_SELECT;
      end
      ST_SELECT: begin
        if (w_abortNow || (r_pending == '0)) begin
          w_nextState = ST_FINISH;
        end else if ((|(r_inv & w_lowOh)) != r_clkInvSel) begin
          w_polFlip   = 1'b1;
          w_nextState = ST_SETTLE;
        end else begin
          w_nextState = ST_RUN;
        end
      end
      ST_SETTLE: begin
        if (w_abortNow)                  w_nextState = ST_FINISH;
        else if (w_count == SETTLE_LAST) w_nextState = ST_RUN;
      end
      ST_RUN: begin
        if (w_abortNow) begin
          w_nextState = ST_FINISH;
        end else if (w_activeDone) begin
          w_runDone   = 1'b1;
          w_nextState = ST_RELEASE;
        end
`ifdef MBIST_SCHED_TIMEOUT_EN
        else if (w_count == WDOG_LAST) begin
          w_runTimeout = 1'b1;
          w_nextState  = ST_SELECT;
        end
`endif
      end
      ST_RELEASE: begin
        if (w_abortNow)         w_nextState = ST_FINISH;
        else if (!w_activeDone) w_nextState = ST_SELECT;
      end
      ST_FINISH: w_nextState = ST_IDLE;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Clearing on every state change restarts the count on entry to SETTLE and RUN.
  always_comb begin
    w_cntLoad     = (w_nextState != r_state);
    w_cntInc      = (r_state == ST_SETTLE) || (r_state == ST_RUN);
    w_enterFinish = (w_nextState == ST_FINISH) && (r_state != ST_FINISH);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_pending   <= '0;
      r_inv       <= '0;
      r_sel       <= '0;
      r_failVec   <= '0;
      r_clkInvSel <= 1'b0;
      r_timeout   <= 1'b0;
      r_pass      <= 1'b1;
    end else begin
      if ((r_state == ST_IDLE) && start_i) begin
        r_pending <= enable_mask_i;
        r_inv     <= invert_mask_i;
        r_failVec <= '0;
        r_timeout <= 1'b0;
        r_pass    <= 1'b1;
      end
      if (r_state == ST_SELECT) r_sel <= w_lowOh;
      if (w_polFlip) r_clkInvSel <= ~r_clkInvSel;
      if (w_runDone) begin
        r_pending <= r_pending & ~r_sel;
        if (w_activeFail) r_failVec <= r_failVec | r_sel;
      end
      if (w_runTimeout) begin
        r_pending <= r_pending & ~r_sel;
        r_failVec <= r_failVec | r_sel;
        r_timeout <= 1'b1;
      end
      if (w_enterFinish) r_pass <= !w_abortNow && (r_failVec == '0);
    end
  end

  assign ctrl_start_o  = (r_state == ST_RUN) ? r_sel : '0;
  assign clk_inv_sel_o = r_clkInvSel;
  assign busy_o        = (r_state != ST_IDLE) && (r_state != ST_FINISH);
  assign done_o        = (r_state == ST_FINISH);
  assign pass_o        = r_pass;
  assign fail_vec_o    = r_failVec;
  // Without the watchdog nothing ever sets r_timeout, so this output stays 0.
  assign timeout_o     = r_timeout;

endmodule
